// File: rtl/bulls_and_cows_seq.sv
// bulls_and_cows_seq: serial 4-digit Bulls-and-Cows scorer.
// One guess digit per clock; the result is published on the edge that samples digit 3.
`default_nettype none

module bulls_and_cows_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] number_in,
  input  logic [3:0] secret_number_0,
  input  logic [3:0] secret_number_1,
  input  logic [3:0] secret_number_2,
  input  logic [3:0] secret_number_3,
  output logic [2:0] bulls,
  output logic [2:0] cows,
  output logic       valid,
  output logic       win
);

  logic [1:0] pos_q,   pos_d;
  logic [2:0] bacc_q,  bacc_d;
  logic [2:0] cacc_q,  cacc_d;
  logic [2:0] bulls_q, bulls_d;
  logic [2:0] cows_q,  cows_d;
  logic       valid_q, valid_d;
  logic       win_q,   win_d;

  logic [3:0] secret [4];
  logic       bull_w;
  logic       cow_w;
  logic [2:0] bull_sum_w;
  logic [2:0] cow_sum_w;

  assign secret[0] = secret_number_0;
  assign secret[1] = secret_number_1;
  assign secret[2] = secret_number_2;
  assign secret[3] = secret_number_3;

  // A digit that is a bull is never also counted as a cow.
  always_comb begin
    bull_w = (number_in == secret[pos_q]);
    cow_w  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) != pos_q) && (number_in == secret[j])) begin
        cow_w = 1'b1;
      end
    end
    if (bull_w) begin
      cow_w = 1'b0;
    end
  end

  assign bull_sum_w = bacc_q + {2'b00, bull_w};
  assign cow_sum_w  = cacc_q + {2'b00, cow_w};

  always_comb begin
    pos_d   = pos_q + 2'd1;
    bacc_d  = bull_sum_w;
    cacc_d  = cow_sum_w;
    bulls_d = bulls_q;
    cows_d  = cows_q;
    win_d   = win_q;
    valid_d = 1'b0;
    if (pos_q == 2'd3) begin
      bulls_d = bull_sum_w;
      cows_d  = cow_sum_w;
      win_d   = (bull_sum_w == 3'd4);
      valid_d = 1'b1;
      bacc_d  = 3'd0;
      cacc_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q   <= 2'd0;
      bacc_q  <= 3'd0;
      cacc_q  <= 3'd0;
      bulls_q <= 3'd0;
      cows_q  <= 3'd0;
      valid_q <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      bacc_q  <= bacc_d;
      cacc_q  <= cacc_d;
      bulls_q <= bulls_d;
      cows_q  <= cows_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  assign bulls = bulls_q;
  assign cows  = cows_q;
  assign valid = valid_q;
  assign win   = win_q;

endmodule

`default_nettype wire

// File: tb/tb_bulls_and_cows_seq.sv
// tb_bulls_and_cows_seq: scoreboard bench for the serial Bulls-and-Cows scorer.
`default_nettype none

module tb_bulls_and_cows_seq;

  typedef struct packed {
    logic [2:0] b;
    logic [2:0] c;
    logic       w;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] number_in = 4'd0;
  logic [3:0] sec [4];
  logic [2:0] bulls;
  logic [2:0] cows;
  logic       valid;
  logic       win;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   vcount;
  int   valid_cyc;
  res_t q [$];

  bulls_and_cows_seq dut (
    .clk             (clk),
    .rst             (rst),
    .number_in       (number_in),
    .secret_number_0 (sec[0]),
    .secret_number_1 (sec[1]),
    .secret_number_2 (sec[2]),
    .secret_number_3 (sec[3]),
    .bulls           (bulls),
    .cows            (cows),
    .valid           (valid),
    .win             (win)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] mk(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  // Reference scoring straight from the game rule.
  function automatic res_t model(input logic [15:0] g);
    res_t       r;
    logic [3:0] d;
    logic       hit;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      d = g[4*i +: 4];
      if (d == sec[i]) begin
        r.b = r.b + 3'd1;
      end else begin
        hit = 1'b0;
        for (int j = 0; j < 4; j++) if (j != i && d == sec[j]) hit = 1'b1;
        if (hit) r.c = r.c + 3'd1;
      end
    end
    r.w = (r.b == 3'd4);
    return r;
  endfunction

  // Starts anywhere before the sampling edge; returns on the following negedge.
  task automatic drive_digit(input logic [3:0] d);
    number_in = d;
    @(posedge clk);
    #1;
    if (valid === 1'b1) begin
      vcount++;
      valid_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic send_guess(input logic [15:0] g, input res_t exp);
    q.push_back(exp);
    vcount = 0;
    for (int i = 0; i < 4; i++) drive_digit(g[4*i +: 4]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic set_secret(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    sec[0] = a; sec[1] = b; sec[2] = c; sec[3] = d;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({bulls, cows, valid, win} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got b=%0d c=%0d v=%b w=%b, want all 0", bulls, cows, valid, win);
    end
    do_reset();
  endtask

  task automatic test_guess(input string name, input logic [15:0] g,
                            input logic [2:0] eb, input logic [2:0] ec, input logic ew);
    res_t e;
    do_reset();
    send_guess(g, '{b: eb, c: ec, w: ew});
    e = q.pop_front();
    n_vec++;
    if (vcount !== 1 || valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_valid: got pulses=%0d valid_now=%b, want 1 on 4th edge", name, vcount, valid);
    end
    n_vec++;
    if ({bulls, cows, win} !== e) begin
      n_err++;
      $display("FAIL %s_result: got b=%0d c=%0d w=%b, want b=%0d c=%0d w=%b",
               name, bulls, cows, win, e.b, e.c, e.w);
    end
    vcount = 0;
    drive_digit(4'd9);
    n_vec++;
    if (vcount !== 0 || {bulls, cows, win} !== e) begin
      n_err++;
      $display("FAIL %s_hold: got valid=%0d b=%0d c=%0d w=%b, want valid 0 b=%0d c=%0d w=%b",
               name, vcount, bulls, cows, win, e.b, e.c, e.w);
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    int   c1;
    do_reset();
    send_guess(mk(0, 1, 2, 3), '{b: 3'd4, c: 3'd0, w: 1'b1});
    c1 = valid_cyc;
    e  = q.pop_front();
    n_vec++;
    if (vcount !== 1 || {bulls, cows, win} !== e) begin
      n_err++;
      $display("FAIL b2b_first: got pulses=%0d b=%0d c=%0d w=%b, want 1 b=%0d c=%0d w=%b",
               vcount, bulls, cows, win, e.b, e.c, e.w);
    end
    send_guess(mk(8, 1, 2, 0), '{b: 3'd2, c: 3'd1, w: 1'b0});
    e = q.pop_front();
    n_vec++;
    if (vcount !== 1 || valid !== 1'b1 || {bulls, cows, win} !== e) begin
      n_err++;
      $display("FAIL b2b_second: got pulses=%0d b=%0d c=%0d w=%b, want 1 b=%0d c=%0d w=%b",
               vcount, bulls, cows, win, e.b, e.c, e.w);
    end
    n_vec++;
    if (valid_cyc - c1 !== 4) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d cycles between valids, want 4", valid_cyc - c1);
    end
  endtask

  task automatic test_reset_mid_guess();
    res_t e;
    do_reset();
    send_guess(mk(0, 1, 2, 3), '{b: 3'd4, c: 3'd0, w: 1'b1});
    e = q.pop_front();
    n_vec++;
    if ({bulls, cows, win} !== e) begin
      n_err++;
      $display("FAIL midrst_setup: got b=%0d c=%0d w=%b, want 4/0/1", bulls, cows, win);
    end
    drive_digit(4'd0);
    drive_digit(4'd1);
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({bulls, cows, valid, win} !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_async_clear: got b=%0d c=%0d v=%b w=%b, want all 0", bulls, cows, valid, win);
    end
    #1 rst = 1'b1;
    send_guess(mk(3, 2, 1, 0), '{b: 3'd0, c: 3'd4, w: 1'b0});
    e = q.pop_front();
    n_vec++;
    if (vcount !== 1 || valid !== 1'b1 || {bulls, cows, win} !== e) begin
      n_err++;
      $display("FAIL midrst_after: got pulses=%0d v=%b b=%0d c=%0d w=%b, want 1 1 b=0 c=4 w=0",
               vcount, valid, bulls, cows, win);
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] g;
    res_t        e;
    set_secret(4'd5, 4'd9, 4'd2, 4'd14);
    do_reset();
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: g[4*i +: 4] = sec[i];
          1: g[4*i +: 4] = sec[$urandom_range(0, 3)];
          default: g[4*i +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      send_guess(g, model(g));
      e = q.pop_front();
      n_vec++;
      if (vcount !== 1 || {bulls, cows, win} !== e || bulls + cows > 3'd4) begin
        n_err++;
        $display("FAIL rand_%0d: guess=%h got pulses=%0d b=%0d c=%0d w=%b, want 1 b=%0d c=%0d w=%b",
                 k, g, vcount, bulls, cows, win, e.b, e.c, e.w);
      end
    end
  endtask

  initial begin
    set_secret(4'd0, 4'd1, 4'd2, 4'd3);
    test_reset();
    test_guess("win",      mk(0, 1, 2, 3), 3'd4, 3'd0, 1'b1);
    test_guess("allcows",  mk(3, 2, 1, 0), 3'd0, 3'd4, 1'b0);
    test_guess("onecow",   mk(7, 8, 9, 1), 3'd0, 3'd1, 1'b0);
    test_guess("mixed",    mk(8, 1, 2, 0), 3'd2, 3'd1, 1'b0);
    test_guess("repeat",   mk(1, 1, 1, 1), 3'd1, 3'd3, 1'b0);
    test_guess("hi_vals",  mk(15, 10, 12, 3), 3'd1, 3'd0, 1'b0);
    test_back_to_back();
    test_reset_mid_guess();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
